pipeline_ctrl_gen: RTL and testbench
====================================

# pipeline_ctrl_gen

Parametrised pipeline stall/flush controller for the multi-stage CPU core. It is the generalised successor of the fixed six-stage controller. It turns a per-stage stall-request vector into per-stage stall and bubble controls, and arbitrates exception/ERET redirects into a flush with a target PC. An exception that arrives during a whole-pipeline stall is captured and replayed, not dropped. Flush can be stretched over several cycles, and a watchdog flags stalls that last too long. It sits beside the pipeline registers and receives requests from ID/EX/MEM and the memory interface.

## Interface
- NUM_STAGES, 6, pipeline control points; index 0 = PC, ascending toward WB
- ADDR_W, 32, PC width
- FLUSH_CYCLES, 1, cycles flush stays asserted per redirect (≥1)
- TIMEOUT, 1024, consecutive stalled cycles before stall_timeout (≥2)
- RESET_VEC, 32'hbfc0_0000, target for non-trap exceptions
- TRAP_VEC, 32'hbfc0_0380, target for syscall/break
---
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_req  in  NUM_STAGES  per-stage stall request; bit i asks stages 0..i to hold
- stall_all  in  1  freeze every stage (bus wait)
- cp0_epc  in  ADDR_W  ERET return address
- eret_flag  in  1  ERET committing
- trap_flag  in  1  syscall or break committing
- exc_flag  in  1  other exception committing (e.g. overflow/zero)
- stall  out  NUM_STAGES  hold stage i
- bubble  out  NUM_STAGES  insert NOP into stage i's register this cycle
- flush  out  1  flush all stages, redirect PC
- exc_pc  out  ADDR_W  redirect target, valid while flush=1
- stall_timeout  out  1  watchdog flag

## Operation
- Stall: stall[i] = stall_all | OR(stall_req[NUM_STAGES-1:i]).
- Bubble: bubble[i] = 1 when stall[i-1]=1, stall[i]=0 and stall_all=0. bubble[0] = 0.
- Redirect priority: eret_flag > trap_flag > exc_flag.
- Targets: ERET → cp0_epc, trap → TRAP_VEC, exc → RESET_VEC.
- FSM states:
  - IDLE:
    - Any flag with stall_all=0 → flush=1 combinationally, exc_pc from the current inputs. If FLUSH_CYCLES>1, latch the target and go to FLUSH.
    - Any flag with stall_all=1 → latch the target, go to PENDING. Flush stays 0.
  - PENDING: flags are ignored. When stall_all falls, flush=1 with the latched exc_pc in that cycle, then go to FLUSH, or to IDLE if FLUSH_CYCLES=1.
  - FLUSH: flush=1 with the latched exc_pc. A down-counter covers the remaining FLUSH_CYCLES-1 cycles, then the FSM returns to IDLE. New flags are ignored because they come from flushed instructions. stall_all=1 freezes the counter and forces flush=0.
- When flush=1, bubble is all zeros. Stall still follows the stall equation.
- Watchdog: a saturating counter of width clog2(TIMEOUT+1) increments on every cycle with any stall bit set and clears on any cycle with none. stall_timeout = (count == TIMEOUT). The flag is sticky until the stall drops.

## Timing
- Reset (rst_n low, async):
  - FSM → IDLE, counters → 0, latched target → RESET_VEC.
  - Outputs: stall all ones, bubble 0, flush 0, exc_pc RESET_VEC, stall_timeout 0.
- After rst_n rises, stall returns to the combinational equation on the same cycle.
- Zero-latency path: inputs to stall, bubble and flush in IDLE.
- PENDING replay: flush rises in the cycle where stall_all=0 is sampled.
- Simultaneous flags: resolved by priority. Only one redirect is produced.
- stall_all rising in the same cycle as a flag: PENDING, not flush.
- Watchdog: with stall held from cycle 0, stall_timeout rises after TIMEOUT edges.
- Reset mid-PENDING or mid-FLUSH: the redirect is discarded.

## Structure
- Shared package/header (bus.v style):
  - exception vector constants RESET_VEC and TRAP_VEC
  - FSM state encoding: IDLE=0, PENDING=1, FLUSH=2 (2 bits)
  - redirect-select encoding
- Sub-module stall_watchdog: counter plus flag, parameterised by TIMEOUT. Everything else lives in one module.

## Test plan
- stall_req=6'b000100, stall_all=0 → stall=6'b000111, bubble=6'b001000, flush=0.
- eret_flag=1 and trap_flag=1 together, cp0_epc=32'h8000_1234 → same-cycle flush=1, exc_pc=32'h8000_1234.
- trap_flag=1 pulse while stall_all=1 for 5 cycles → flush=0 throughout. Flush=1 with exc_pc=32'hbfc0_0380 in the first cycle stall_all=0.
- FLUSH_CYCLES=3, exc_flag pulse → flush high exactly 3 cycles with exc_pc=32'hbfc0_0000. An eret_flag in cycle 2 is ignored.
- TIMEOUT=8, stall_req[3] held 10 cycles → stall_timeout rises after 8 edges. It clears the cycle after the request drops.
- rst_n low during PENDING → stall=all ones, flush=0, exc_pc=RESET_VEC. After release, no replayed flush.

Source files
------------

// File: rtl/pipeline_ctrl_gen_pkg.sv
// Shared constants and encodings for the pipeline stall/flush controller.
// Exception vectors, FSM states and redirect-select codes.
package pipeline_ctrl_gen_pkg;

  localparam logic [31:0] RESET_VEC = 32'hbfc0_0000;
  localparam logic [31:0] TRAP_VEC  = 32'hbfc0_0380;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ERET = 2'd1,
    SEL_TRAP = 2'd2,
    SEL_EXC  = 2'd3
  } redir_e;

  // Flags may overlap, so this is a priority pick, not a one-hot decode.
  function automatic redir_e redir_sel(
    input logic eret,
    input logic trap,
    input logic exc
  );
    if (eret)      return SEL_ERET;
    else if (trap) return SEL_TRAP;
    else if (exc)  return SEL_EXC;
    else           return SEL_NONE;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_gen_if.sv
// Request/control bundle between the pipeline and its stall/flush controller.
// master = pipeline side, slave = controller side.
interface pipeline_ctrl_gen_if #(
  parameter int NUM_STAGES = 6,
  parameter int ADDR_W     = 32
);

  logic [NUM_STAGES-1:0] stall_req;
  logic                  stall_all;
  logic [ADDR_W-1:0]     cp0_epc;
  logic                  eret_flag;
  logic                  trap_flag;
  logic                  exc_flag;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] bubble;
  logic                  flush;
  logic [ADDR_W-1:0]     exc_pc;
  logic                  stall_timeout;

  modport master (
    output stall_req, stall_all, cp0_epc,
    output eret_flag, trap_flag, exc_flag,
    input  stall, bubble, flush, exc_pc,
    input  stall_timeout
  );

  modport slave (
    input  stall_req, stall_all, cp0_epc,
    input  eret_flag, trap_flag, exc_flag,
    output stall, bubble, flush, exc_pc,
    output stall_timeout
  );

endinterface

// File: rtl/pipeline_ctrl_gen_stall_watchdog.sv
// Stall watchdog: saturating count of consecutive stalled cycles.
// Flag holds while the count sits at TIMEOUT.
module pipeline_ctrl_gen_stall_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall_any_i,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count stalled cycles, saturate at the limit, clear on a free cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (!stall_any_i)        cnt_d = '0;
    else if (cnt_q != LIMIT) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign timeout_o = (cnt_q == LIMIT);

endmodule

// File: rtl/pipeline_ctrl_gen.sv
// Pipeline stall/bubble generator and exception/ERET redirect arbiter.
// Redirects seen under a full freeze are held and replayed afterwards.
module pipeline_ctrl_gen #(
  parameter int NUM_STAGES   = 6,
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int TIMEOUT      = 1024,
  parameter logic [ADDR_W-1:0] RESET_VEC =
    pipeline_ctrl_gen_pkg::RESET_VEC,
  parameter logic [ADDR_W-1:0] TRAP_VEC  =
    pipeline_ctrl_gen_pkg::TRAP_VEC
) (
  input logic               clk,
  input logic               rst_n,
  pipeline_ctrl_gen_if.slave ctl
);

  import pipeline_ctrl_gen_pkg::*;

  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] FC_REM = CW'(FLUSH_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]     tgt_q, tgt_d;
  logic [ADDR_W-1:0]     tgt_sel;
  redir_e                sel;
  logic                  flush;
  logic [ADDR_W-1:0]     exc_pc;
  logic                  acc;
  logic [NUM_STAGES-1:0] stall_eq;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] bubble;

  // A request at stage i holds every stage upstream of it.
  always_comb begin
    stall_eq = '0;
    acc      = ctl.stall_all;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      acc         = acc | ctl.stall_req[i];
      stall_eq[i] = acc;
    end
  end

  assign stall = rst_n ? stall_eq : '1;

  // NOP goes into the first moving stage behind a held one.
  always_comb begin
    bubble = '0;
    for (int i = 1; i < NUM_STAGES; i++)
      bubble[i] = stall[i-1] & ~stall[i];
    if (ctl.stall_all || flush || !rst_n) bubble = '0;
  end

  assign sel = redir_sel(ctl.eret_flag, ctl.trap_flag,
                         ctl.exc_flag);

  // Redirect target for the winning flag.
  always_comb begin
    tgt_sel = RESET_VEC;
    unique case (sel)
      SEL_ERET: tgt_sel = ctl.cp0_epc;
      SEL_TRAP: tgt_sel = TRAP_VEC;
      default:  tgt_sel = RESET_VEC;
    endcase
  end

  // Redirect FSM: next state, latched target and flush output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    flush   = 1'b0;
    exc_pc  = tgt_q;
    unique case (state_q)
      IDLE: begin
        if (sel != SEL_NONE) begin
          tgt_d = tgt_sel;
          if (ctl.stall_all) begin
            state_d = PENDING;
          end else begin
            flush  = 1'b1;
            exc_pc = tgt_sel;
            if (FLUSH_CYCLES > 1) begin
              cnt_d   = FC_REM;
              state_d = FLUSH;
            end
          end
        end
      end
      PENDING: begin
        if (!ctl.stall_all) begin
          flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            cnt_d   = FC_REM;
            state_d = FLUSH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (!ctl.stall_all) begin
          flush = 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= CW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, flush counter and target registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= RESET_VEC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  pipeline_ctrl_gen_stall_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_any_i (|stall),
    .timeout_o   (ctl.stall_timeout)
  );

  assign ctl.stall  = stall;
  assign ctl.bubble = bubble;
  assign ctl.flush  = rst_n & flush;
  assign ctl.exc_pc = rst_n ? exc_pc : RESET_VEC;

endmodule

// File: tb/tb_pipeline_ctrl_gen.sv
// Directed bench for pipeline_ctrl_gen.
// FLUSH_CYCLES=3, TIMEOUT=8.
module tb_pipeline_ctrl_gen;

  localparam int NS = 6;
  localparam int AW = 32;
  localparam logic [31:0] RV = 32'hbfc0_0000;
  localparam logic [31:0] TV = 32'hbfc0_0380;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_gen_if #(.NUM_STAGES(NS), .ADDR_W(AW)) bus ();

  pipeline_ctrl_gen #(
    .NUM_STAGES   (NS),
    .ADDR_W       (AW),
    .FLUSH_CYCLES (3),
    .TIMEOUT      (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.stall_req = '0;
    bus.stall_all = 1'b0;
    bus.cp0_epc   = '0;
    bus.eret_flag = 1'b0;
    bus.trap_flag = 1'b0;
    bus.exc_flag  = 1'b0;
  endtask

  task automatic chk_fl(input string tag, input logic f,
                        input logic [31:0] pc);
    chk({tag, "_flush"}, 32'(bus.flush), 32'(f));
    if (f) chk({tag, "_pc"}, bus.exc_pc, pc);
  endtask

  initial begin
    clr();
    #2;
    chk("rst_stall", 32'(bus.stall), 32'h3f);
    chk("rst_bubble", 32'(bus.bubble), 32'h0);
    chk("rst_flush", 32'(bus.flush), 32'h0);
    chk("rst_pc", bus.exc_pc, RV);
    chk("rst_tmo", 32'(bus.stall_timeout), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rel_stall", 32'(bus.stall), 32'h0);

    nxt();
    bus.stall_req = 6'b000100;
    #1;
    chk("st_stall", 32'(bus.stall), 32'h07);
    chk("st_bubble", 32'(bus.bubble), 32'h08);
    chk("st_flush", 32'(bus.flush), 32'h0);

    nxt();
    bus.stall_req = 6'b000100;
    bus.eret_flag = 1'b1;
    bus.trap_flag = 1'b1;
    bus.cp0_epc   = 32'h8000_1234;
    #1;
    chk_fl("eret0", 1'b1, 32'h8000_1234);
    chk("eret_stall", 32'(bus.stall), 32'h07);
    chk("eret_bubble", 32'(bus.bubble), 32'h0);
    nxt();
    clr();
    #1 chk_fl("eret1", 1'b1, 32'h8000_1234);
    nxt();
    #1 chk_fl("eret2", 1'b1, 32'h8000_1234);
    nxt();
    #1 chk_fl("eret3", 1'b0, 32'h0);

    nxt();
    bus.stall_all = 1'b1;
    bus.trap_flag = 1'b1;
    #1 chk_fl("pend0", 1'b0, 32'h0);
    chk("pend_stall", 32'(bus.stall), 32'h3f);
    for (int k = 1; k < 5; k++) begin
      nxt();
      bus.trap_flag = 1'b0;
      #1 chk_fl("pendk", 1'b0, 32'h0);
    end
    nxt();
    bus.stall_all = 1'b0;
    #1 chk_fl("replay0", 1'b1, TV);
    nxt();
    #1 chk_fl("replay1", 1'b1, TV);
    nxt();
    #1 chk_fl("replay2", 1'b1, TV);
    nxt();
    #1 chk_fl("replay3", 1'b0, 32'h0);

    nxt();
    bus.exc_flag = 1'b1;
    #1 chk_fl("exc0", 1'b1, RV);
    nxt();
    bus.exc_flag  = 1'b0;
    bus.eret_flag = 1'b1;
    bus.cp0_epc   = 32'h1234_5678;
    #1 chk_fl("exc1", 1'b1, RV);
    nxt();
    clr();
    #1 chk_fl("exc2", 1'b1, RV);
    nxt();
    #1 chk_fl("exc3", 1'b0, 32'h0);

    nxt();
    bus.stall_req = 6'b001000;
    for (int j = 0; j < 10; j++) begin
      #1;
      chk("wd_stall", 32'(bus.stall), 32'h0f);
      chk("wd_bubble", 32'(bus.bubble), 32'h10);
      chk("wd_tmo", 32'(bus.stall_timeout), 32'(j >= 8));
      nxt();
    end
    bus.stall_req = '0;
    #1 chk("wd_drop", 32'(bus.stall_timeout), 32'h1);
    nxt();
    #1 chk("wd_clear", 32'(bus.stall_timeout), 32'h0);

    nxt();
    bus.stall_all = 1'b1;
    bus.trap_flag = 1'b1;
    #1 chk_fl("rp0", 1'b0, 32'h0);
    nxt();
    bus.trap_flag = 1'b0;
    #1 chk_fl("rp1", 1'b0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("rp_rst_stall", 32'(bus.stall), 32'h3f);
    chk("rp_rst_flush", 32'(bus.flush), 32'h0);
    chk("rp_rst_pc", bus.exc_pc, RV);
    nxt();
    rst_n = 1'b1;
    bus.stall_all = 1'b0;
    #1 chk_fl("rp_rel", 1'b0, 32'h0);
    chk("rp_rel_pc", bus.exc_pc, RV);
    nxt();
    #1 chk_fl("rp_rel1", 1'b0, 32'h0);
    nxt();
    #1 chk_fl("rp_rel2", 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
